// File: rtl/weight_pref_pkg.sv
// Shared types and helpers for the ping-pong weight prefetcher.
package weight_pref_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } shadow_state_e;

  function automatic int unsigned depth(input int unsigned rows, input int unsigned cols,
                                        input int unsigned groups);
    return rows * cols * groups;
  endfunction

  // Bit offset of PE (r,c) inside a packed group of weights.
  function automatic int unsigned pe_off(input int unsigned r, input int unsigned c,
                                         input int unsigned cols, input int unsigned n);
    return (r * cols + c) * n;
  endfunction

endpackage

// File: rtl/weight_pref_bank.sv
// One weight bank: DEPTH x N storage, two-weight write port, whole-group async read.
module weight_pref_bank
  import weight_pref_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 8,
  parameter int unsigned GROUPS = 3,
  localparam int unsigned RC    = ROWS * COLS,
  localparam int unsigned DEPTH = depth(ROWS, COLS, GROUPS),
  localparam int unsigned PW    = $clog2(DEPTH / 2) + 1,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     wr_ptr,
  input  logic [2*N-1:0]    wdata,
  input  logic [GW-1:0]     grp,
  output logic [RC*N-1:0]   rdata
);

  logic [N-1:0] mem [DEPTH];
  logic [AW-1:0] wa0, wa1;

  assign wa0 = AW'({wr_ptr, 1'b0});
  assign wa1 = AW'({wr_ptr, 1'b1});

  // Storage is never reset: validity is tracked by the owner's fill state.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa0] <= wdata[N-1:0];
      mem[wa1] <= wdata[2*N-1:N];
    end
  end

  for (genvar i = 0; i < RC; i++) begin : g_rd
    assign rdata[i*N +: N] = mem[AW'(32'(grp) * RC + 32'(i))];
  end

endmodule

// File: rtl/weight_pref_pingpong.sv
// Ping-pong weight prefetcher feeding a ROWS x COLS systolic array.
// Optional zero-weight mask output enabled by WEIGHT_PREF_ZSKIP_EN.
module weight_pref_pingpong
  import weight_pref_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 8,
  parameter int unsigned GROUPS = 3,
  localparam int unsigned RC    = ROWS * COLS,
  localparam int unsigned DEPTH = depth(ROWS, COLS, GROUPS),
  localparam int unsigned PW    = $clog2(DEPTH / 2) + 1,
  localparam int unsigned GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*N-1:0]    in_data,
  output logic              shadow_full,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              grp_adv,
  output logic [GW-1:0]     grp_idx,
  output logic              grp_last,
  output logic              out_valid,
  output logic [RC*N-1:0]   out_weights
`ifdef WEIGHT_PREF_ZSKIP_EN
  , output logic [RC-1:0]   out_zero_mask
`endif
);

  localparam logic [PW-1:0] LAST_BEAT = PW'(DEPTH / 2 - 1);
  localparam logic [GW-1:0] LAST_GRP  = GW'(GROUPS - 1);

  if ((DEPTH % 2) != 0) begin : g_depth_chk
    $error("weight_pref_pingpong: ROWS*COLS*GROUPS must be even");
  end

  shadow_state_e state, state_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d;
  logic          sel, sel_d;
  logic [GW-1:0] grp_d;
  logic          out_valid_d, grp_last_d;
  logic          accept_c, swap_c;
  logic [RC*N-1:0] rd0, rd1, rd_sel;

  assign accept_c = in_valid & in_ready;
  assign swap_c   = swap_req & shadow_full;
  assign swap_ack = swap_c;

  // Bank `sel` is active; the other one is the shadow being filled.
  weight_pref_bank #(.N(N), .ROWS(ROWS), .COLS(COLS), .GROUPS(GROUPS)) u_bank0 (
    .clk    (clk),
    .we     (accept_c & sel),
    .wr_ptr (wr_ptr),
    .wdata  (in_data),
    .grp    (grp_d),
    .rdata  (rd0)
  );

  weight_pref_bank #(.N(N), .ROWS(ROWS), .COLS(COLS), .GROUPS(GROUPS)) u_bank1 (
    .clk    (clk),
    .we     (accept_c & ~sel),
    .wr_ptr (wr_ptr),
    .wdata  (in_data),
    .grp    (grp_d),
    .rdata  (rd1)
  );

  assign rd_sel = sel_d ? rd1 : rd0;

  // Shadow fill FSM plus bank select and group sequencing.
  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    sel_d       = sel;
    grp_d       = grp_idx;
    out_valid_d = out_valid;
    grp_last_d  = 1'b0;

    unique case (state)
      EMPTY, FILLING: begin
        if (accept_c) begin
          wr_ptr_d = wr_ptr + PW'(1);
          state_d  = (wr_ptr == LAST_BEAT) ? FULL : FILLING;
        end
      end
      FULL: begin
        if (swap_c) begin
          state_d  = EMPTY;
          wr_ptr_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A taken swap overrides any coincident group advance.
    if (swap_c) begin
      sel_d       = ~sel;
      out_valid_d = 1'b1;
      grp_d       = '0;
    end else if (grp_adv && out_valid) begin
      if (grp_idx == LAST_GRP) begin
        grp_d      = '0;
        grp_last_d = 1'b1;
      end else begin
        grp_d = grp_idx + GW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      sel         <= 1'b0;
      grp_idx     <= '0;
      grp_last    <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      shadow_full <= 1'b0;
      out_weights <= '0;
    end else begin
      wr_ptr      <= wr_ptr_d;
      sel         <= sel_d;
      grp_idx     <= grp_d;
      grp_last    <= grp_last_d;
      out_valid   <= out_valid_d;
      in_ready    <= (state_d != FULL);
      shadow_full <= (state_d == FULL);
      out_weights <= out_valid_d ? rd_sel : '0;
    end
  end

`ifdef WEIGHT_PREF_ZSKIP_EN
  logic [RC-1:0] zmask_d;

  always_comb begin
    zmask_d = '0;
    for (int i = 0; i < int'(RC); i++) begin
      zmask_d[i] = out_valid_d && (rd_sel[i*N +: N] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_zero_mask <= '0;
    end else begin
      out_zero_mask <= zmask_d;
    end
  end
`else
  // Default build: no zero-weight compare logic.
`endif

endmodule

// File: tb/tb_weight_pref_pingpong.sv
// Directed self-checking bench for weight_pref_pingpong (4x8x3, N=8).
module tb_weight_pref_pingpong;

  localparam int N = 8;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int GROUPS = 3;
  localparam int BEATS = ROWS * COLS * GROUPS / 2;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [2*N-1:0] in_data;
  logic shadow_full;
  logic swap_req;
  logic swap_ack;
  logic grp_adv;
  logic [1:0] grp_idx;
  logic grp_last;
  logic out_valid;
  logic [ROWS*COLS*N-1:0] out_weights;
`ifdef WEIGHT_PREF_ZSKIP_EN
  logic [ROWS*COLS-1:0] out_zero_mask;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  weight_pref_pingpong #(.N(N), .ROWS(ROWS), .COLS(COLS), .GROUPS(GROUPS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .shadow_full (shadow_full),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .grp_adv     (grp_adv),
    .grp_idx     (grp_idx),
    .grp_last    (grp_last),
    .out_valid   (out_valid),
    .out_weights (out_weights)
`ifdef WEIGHT_PREF_ZSKIP_EN
    , .out_zero_mask (out_zero_mask)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pe(input int r, input int c);
    return out_weights[(r*COLS+c)*N +: N];
  endfunction

  // Weight value for index k under each load pattern.
  function automatic logic [7:0] wfn(input int p, input int k);
    case (p)
      1: return 8'(k);
      2: return 8'(255 - k);
      3: return 8'(k) ^ 8'h55;
      default: return (k == 5) ? 8'h00 : 8'(k + 1);
    endcase
  endfunction

  task automatic load(input int p, input int first, input int count, input logic hold_req);
    for (int b = first; b < first + count; b++) begin
      in_valid = 1'b1;
      in_data  = {wfn(p, 2*b+1), wfn(p, 2*b)};
      #1;
      chk("in_ready_during_fill", 64'(in_ready), 64'd1);
      if (hold_req) chk("no_ack_while_filling", 64'(swap_ack), 64'd0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},    64'(in_ready),    64'd1);
    chk({tag, "_shadow_full"}, 64'(shadow_full), 64'd0);
    chk({tag, "_grp_idx"},     64'(grp_idx),     64'd0);
    chk({tag, "_grp_last"},    64'(grp_last),    64'd0);
    chk({tag, "_out_valid"},   64'(out_valid),   64'd0);
    chk({tag, "_weights_zero"}, 64'(out_weights == '0), 64'd1);
`ifdef WEIGHT_PREF_ZSKIP_EN
    chk({tag, "_zmask"}, 64'(out_zero_mask), 64'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    swap_req = 1'b0; grp_adv = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_vals("rst");
    chk("rst_swap_ack", 64'(swap_ack), 64'd0);

    // 1: full load, pattern weight k = k
    load(1, 0, BEATS, 1'b0);
    chk("t1_in_ready_low", 64'(in_ready), 64'd0);
    chk("t1_shadow_full", 64'(shadow_full), 64'd1);
    chk("t1_out_valid", 64'(out_valid), 64'd0);

    // 2: swap
    swap_req = 1'b1; #1;
    chk("t2_swap_ack", 64'(swap_ack), 64'd1);
    tick();
    swap_req = 1'b0; #1;
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_grp_idx", 64'(grp_idx), 64'd0);
    chk("t2_pe12", 64'(pe(1, 2)), 64'h0A);
    chk("t2_in_ready", 64'(in_ready), 64'd1);
    chk("t2_shadow_empty", 64'(shadow_full), 64'd0);
    chk("t2_ack_drop", 64'(swap_ack), 64'd0);

    // 3: three group advances with wrap
    grp_adv = 1'b1;
    tick();
    chk("t3_grp1", 64'(grp_idx), 64'd1);
    chk("t3_pe00_g1", 64'(pe(0, 0)), 64'h20);
    chk("t3_last0", 64'(grp_last), 64'd0);
    tick();
    chk("t3_grp2", 64'(grp_idx), 64'd2);
    chk("t3_pe00_g2", 64'(pe(0, 0)), 64'h40);
    tick();
    chk("t3_grp0", 64'(grp_idx), 64'd0);
    chk("t3_pe00_g0", 64'(pe(0, 0)), 64'h00);
    chk("t3_last_pulse", 64'(grp_last), 64'd1);
    chk("t3_valid_kept", 64'(out_valid), 64'd1);
    grp_adv = 1'b0;
    tick();
    chk("t3_last_drop", 64'(grp_last), 64'd0);

    // 4: early swap request ignored until shadow is full
    load(2, 0, 10, 1'b0);
    swap_req = 1'b1; #1;
    chk("t4_no_ack_early", 64'(swap_ack), 64'd0);
    load(2, 10, BEATS - 10, 1'b1);
    chk("t4_active_unchanged", 64'(pe(1, 2)), 64'h0A);
    chk("t4_ack_on_full", 64'(swap_ack), 64'd1);
    tick();
    swap_req = 1'b0; #1;
    chk("t4_pe12_new", 64'(pe(1, 2)), 64'hF5);
    chk("t4_grp_idx", 64'(grp_idx), 64'd0);

    // 5: grp_adv coincident with swap
    load(3, 0, BEATS, 1'b0);
    grp_adv = 1'b1;
    tick();
    chk("t5_grp1", 64'(grp_idx), 64'd1);
    chk("t5_pe00_g1", 64'(pe(0, 0)), 64'hDF);
    swap_req = 1'b1; #1;
    chk("t5_swap_ack", 64'(swap_ack), 64'd1);
    tick();
    swap_req = 1'b0; grp_adv = 1'b0; #1;
    chk("t5_grp0", 64'(grp_idx), 64'd0);
    chk("t5_no_last", 64'(grp_last), 64'd0);
    chk("t5_pe00_new", 64'(pe(0, 0)), 64'h55);
    chk("t5_pe12_new", 64'(pe(1, 2)), 64'h5F);

    // 6: reset mid-fill and mid-read, then refill
    load(4, 0, 20, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("t6");
    grp_adv = 1'b1;
    tick();
    grp_adv = 1'b0;
    chk("t6_adv_ignored", 64'(grp_idx), 64'd0);
    chk("t6_adv_no_last", 64'(grp_last), 64'd0);
    load(4, 0, BEATS, 1'b0);
    chk("t6_refull", 64'(shadow_full), 64'd1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0; #1;
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_pe00", 64'(pe(0, 0)), 64'h01);
    chk("t6_pe05_zero", 64'(pe(0, 5)), 64'h00);
    chk("t6_pe37", 64'(pe(3, 7)), 64'h20);
`ifdef WEIGHT_PREF_ZSKIP_EN
    chk("t6_zmask", 64'(out_zero_mask), 64'h0000_0020);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
